// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ULA between NUM_REQ cores: grants one core,
// drives the ULA for the opcode latency, then returns the result with a done pulse.
module ula_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int LONG_LAT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [8*NUM_REQ-1:0]      req_opcode,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [7:0]                ula_opcode,
  output logic [DATA_W-1:0]         ula_a,
  output logic [DATA_W-1:0]         ula_b,
  output logic                      ula_valid,
  input  logic [DATA_W-1:0]         ula_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LONG_LAT > 1) ? $clog2(LONG_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic [DATA_W-1:0]  rsp_data_d, ula_a_d, ula_b_d;
  logic               rsp_err_d, ula_valid_d;
  logic [7:0]         ula_opcode_d;

  logic [IDX_W-1:0]   win_sel;
  logic [7:0]         sel_op;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic               sel_valid, sel_long;

  // Search for the first requester starting just after the last served core.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    win_sel = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_q) + 1 + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_sel = IDX_W'(idx);
      end
    end
  end

  assign sel_op    = req_opcode[8*int'(win_sel) +: 8];
  assign sel_a     = req_a[DATA_W*int'(win_sel) +: DATA_W];
  assign sel_b     = req_b[DATA_W*int'(win_sel) +: DATA_W];
  assign sel_valid = (sel_op >= 8'd1) && (sel_op <= 8'd12);
  assign sel_long  = (sel_op == 8'd3) || (sel_op == 8'd4) || (sel_op == 8'd5);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    done_d       = '0;
    rsp_data_d   = rsp_data;
    rsp_err_d    = rsp_err;
    ula_opcode_d = ula_opcode;
    ula_a_d      = ula_a;
    ula_b_d      = ula_b;
    ula_valid_d  = ula_valid;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d          = win_sel;
          gnt_d[win_sel] = 1'b1;
          cnt_d          = sel_long ? CNT_W'(LONG_LAT) : CNT_W'(1);
          if (sel_valid) begin
            ula_opcode_d = sel_op;
            ula_a_d      = sel_a;
            ula_b_d      = sel_b;
            ula_valid_d  = 1'b1;
            state_d      = EXEC;
          end else begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = RESP;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d    = ula_result;
          rsp_err_d     = 1'b0;
          done_d[win_q] = 1'b1;
          ula_opcode_d  = '0;
          ula_a_d       = '0;
          ula_b_d       = '0;
          ula_valid_d   = 1'b0;
          state_d       = RESP;
        end
      end
      RESP: begin
        // An invalid opcode enters RESP straight from the grant, so done is raised here first.
        if (done == '0) begin
          done_d[win_q] = 1'b1;
        end else begin
          last_d  = win_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      win_q      <= '0;
      cnt_q      <= '0;
      gnt        <= '0;
      done       <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      ula_opcode <= '0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt        <= gnt_d;
      done       <= done_d;
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      ula_opcode <= ula_opcode_d;
      ula_a      <= ula_a_d;
      ula_b      <= ula_b_d;
      ula_valid  <= ula_valid_d;
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed testbench for ula_arbiter with a behavioural ULA attached to the shared port.
module tb_ula_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int LONG_LAT = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [8*NUM_REQ-1:0]      req_opcode;
  logic [DATA_W*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]        gnt, done;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [7:0]                ula_opcode;
  logic [DATA_W-1:0]         ula_a, ula_b, ula_result;
  logic                      ula_valid;

  int n_cmp = 0;
  int n_bad = 0;

  ula_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .done(done),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .ula_opcode(ula_opcode),
    .ula_a(ula_a), .ula_b(ula_b), .ula_valid(ula_valid), .ula_result(ula_result)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared Controller/ULA: 1=ADD 2=SUB 3=MUL 4=DIV 5=MOD 6=AND 7=OR 8=XOR.
  always_comb begin
    ula_result = '0;
    case (ula_opcode)
      8'd1: ula_result = ula_a + ula_b;
      8'd2: ula_result = ula_a - ula_b;
      8'd3: ula_result = ula_a * ula_b;
      8'd4: ula_result = (ula_b != '0) ? ula_a / ula_b : '0;
      8'd5: ula_result = (ula_b != '0) ? ula_a % ula_b : '0;
      8'd6: ula_result = ula_a & ula_b;
      8'd7: ula_result = ula_a | ula_b;
      8'd8: ula_result = ula_a ^ ula_b;
      default: ula_result = '0;
    endcase
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_core(input int i, input logic [7:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b);
    req_opcode[8*i +: 8]      = op;
    req_a[DATA_W*i +: DATA_W] = a;
    req_b[DATA_W*i +: DATA_W] = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    cyc();
    cyc();
    n_cmp++;
    if ({gnt, done, rsp_err, ula_valid} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {gnt, done, rsp_err, ula_valid});
    end
    n_cmp++;
    if ({rsp_data, ula_opcode, ula_a, ula_b} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_data: got %h expected 0", {rsp_data, ula_opcode, ula_a, ula_b});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_add();
    set_core(2, 8'd1, 8'd5, 8'd3);
    req = 4'b0100;
    cyc();
    n_cmp++;
    if ({gnt, ula_valid, ula_opcode, ula_a, ula_b} !== {4'b0100, 1'b1, 8'd1, 8'd5, 8'd3}) begin
      n_bad++;
      $display("[TB] FAIL add_grant: got gnt=%b v=%b op=%0d a=%0d b=%0d expected gnt=0100 v=1 op=1 a=5 b=3",
               gnt, ula_valid, ula_opcode, ula_a, ula_b);
    end
    n_cmp++;
    if (done !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL add_no_early_done: got %b expected 0000", done);
    end
    req = '0;
    cyc();
    n_cmp++;
    if ({done, rsp_data, rsp_err, gnt, ula_valid} !== {4'b0100, 8'd8, 1'b0, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL add_done: got done=%b data=%0d err=%b gnt=%b v=%b expected 0100 8 0 0000 0",
               done, rsp_data, rsp_err, gnt, ula_valid);
    end
    cyc();
    n_cmp++;
    if ({done, ula_opcode} !== '0) begin
      n_bad++;
      $display("[TB] FAIL add_idle: got done=%b op=%0d expected 0 0", done, ula_opcode);
    end
  endtask

  task automatic test_mul_latency();
    int                 vcnt     = 0;
    int                 done_cyc = 0;
    bit                 stable   = 1'b1;
    logic [NUM_REQ-1:0] g1       = '0;
    logic [NUM_REQ-1:0] d_seen   = '0;
    logic [DATA_W-1:0]  data     = '0;
    set_core(0, 8'd3, 8'd6, 8'd7);
    req = 4'b0001;
    for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
      cyc();
      if (c == 1) begin
        g1  = gnt;
        req = '0;
      end
      if (ula_valid) begin
        vcnt++;
        if (ula_opcode !== 8'd3 || ula_a !== 8'd6 || ula_b !== 8'd7) stable = 1'b0;
      end
      if (done !== '0) begin
        done_cyc = c;
        d_seen   = done;
        data     = rsp_data;
      end
    end
    n_cmp++;
    if (g1 !== 4'b0001) begin
      n_bad++;
      $display("[TB] FAIL mul_grant: got %b expected 0001", g1);
    end
    n_cmp++;
    if (vcnt != LONG_LAT || !stable) begin
      n_bad++;
      $display("[TB] FAIL mul_valid: got %0d cycles stable=%0d expected %0d stable=1", vcnt, stable, LONG_LAT);
    end
    n_cmp++;
    if (done_cyc != LONG_LAT + 1 || d_seen !== 4'b0001 || data !== 8'd42) begin
      n_bad++;
      $display("[TB] FAIL mul_done: got cycle=%0d done=%b data=%0d expected cycle=5 done=0001 data=42",
               done_cyc, d_seen, data);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_g, exp_d;
    int                 gi, di;
    test_reset();
    for (int i = 0; i < NUM_REQ; i++) set_core(i, 8'd1, DATA_W'(i), 8'd10);
    req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      gi    = ((c - 1) / 3) % NUM_REQ;
      di    = ((c - 2) / 3) % NUM_REQ;
      exp_g = ((c - 1) % 3 == 0) ? NUM_REQ'(1) << gi : '0;
      exp_d = (c >= 2 && (c - 2) % 3 == 0) ? NUM_REQ'(1) << di : '0;
      n_cmp++;
      if (gnt !== exp_g || done !== exp_d) begin
        n_bad++;
        $display("[TB] FAIL rr_cycle%0d: got gnt=%b done=%b expected gnt=%b done=%b", c, gnt, done, exp_g, exp_d);
      end
      if (exp_d != '0) begin
        n_cmp++;
        if (rsp_data !== DATA_W'(di + 10)) begin
          n_bad++;
          $display("[TB] FAIL rr_data%0d: got %0d expected %0d", c, rsp_data, di + 10);
        end
      end
    end
    req = '0;
    cyc();
  endtask

  task automatic test_invalid();
    set_core(1, 8'hFF, 8'd9, 8'd9);
    req = 4'b0010;
    cyc();
    n_cmp++;
    if ({gnt, done, ula_valid} !== {4'b0010, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL inv_grant: got gnt=%b done=%b v=%b expected 0010 0000 0", gnt, done, ula_valid);
    end
    req = '0;
    cyc();
    n_cmp++;
    if ({done, rsp_err, rsp_data, gnt, ula_valid} !== {4'b0010, 1'b1, 8'd0, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL inv_done: got done=%b err=%b data=%0d gnt=%b v=%b expected 0010 1 0 0000 0",
               done, rsp_err, rsp_data, gnt, ula_valid);
    end
    cyc();
    n_cmp++;
    if (done !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL inv_single_done: got %b expected 0000", done);
    end
  endtask

  task automatic test_operand_change();
    set_core(3, 8'd2, 8'd9, 8'd4);
    req = 4'b1000;
    cyc();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_bad++;
      $display("[TB] FAIL chg_grant: got %b expected 1000", gnt);
    end
    set_core(3, 8'd2, 8'd0, 8'd0);
    req = '0;
    cyc();
    n_cmp++;
    if (done !== 4'b1000 || rsp_data !== 8'd5) begin
      n_bad++;
      $display("[TB] FAIL chg_result: got done=%b data=%0d expected 1000 5", done, rsp_data);
    end
    cyc();
  endtask

  task automatic test_reset_mid_exec();
    bit stray_done = 1'b0;
    set_core(1, 8'd1, 8'd1, 8'd1);
    req = 4'b0010;
    cyc();
    req = '0;
    cyc();
    n_cmp++;
    if (done !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL pre_abort_done: got %b expected 0010", done);
    end
    cyc();
    set_core(2, 8'd4, 8'd20, 8'd4);
    req = 4'b0100;
    cyc();
    req = '0;
    cyc();
    n_cmp++;
    if (ula_valid !== 1'b1 || ula_opcode !== 8'd4) begin
      n_bad++;
      $display("[TB] FAIL div_running: got v=%b op=%0d expected 1 4", ula_valid, ula_opcode);
    end
    reset = 1'b1;
    cyc();
    n_cmp++;
    if ({gnt, done, rsp_err, ula_valid, rsp_data, ula_opcode, ula_a, ula_b} !== '0) begin
      n_bad++;
      $display("[TB] FAIL abort_outputs: got gnt=%b done=%b err=%b v=%b data=%0d op=%0d a=%0d b=%0d expected all 0",
               gnt, done, rsp_err, ula_valid, rsp_data, ula_opcode, ula_a, ula_b);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (done !== '0 || ula_valid !== 1'b0) stray_done = 1'b1;
    end
    n_cmp++;
    if (stray_done) begin
      n_bad++;
      $display("[TB] FAIL abort_no_done: got activity=1 expected activity=0");
    end
    for (int i = 0; i < NUM_REQ; i++) set_core(i, 8'd1, 8'd2, 8'd2);
    req = 4'b1111;
    cyc();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("[TB] FAIL post_reset_priority: got %b expected 0001", gnt);
    end
    req = '0;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req        = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    test_reset();
    test_single_add();
    test_mul_latency();
    test_round_robin();
    test_invalid();
    test_operand_change();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
